// File: rtl/mem_stage.sv
// mem_stage - memory-access pipeline stage that sits directly after execute.
//
// Takes the execute result, the store data and the memory controls. Loads and
// stores go out over a request/acknowledge data bus. Load data is extended by
// width and signedness. A registered bundle is handed to write-back. stall_o
// freezes the upstream stages while a bus transaction is outstanding.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses raise AdEL/AdES and skip the bus.
//   undefined : no alignment exceptions; the low address bits are forced to
//               the access alignment and the access proceeds.
//
// Parameter
//   TIMEOUT          bus wait cycles before a bus-timeout exception (0 = off)
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   valid_i          live instruction on the input bundle (held while stalled)
//   ALUResult        address for memory ops, result otherwise
//   MemData          store data
//   MemRead/Write    load / store strobes
//   MemReadType      000 word, 001 half s, 010 half u, 011 byte s, 100 byte u
//   RegWrite, MemtoReg, hiloWrite, WriteRegister, hiloData, PCin -> write-back
//   ForwardMEM       combinational copy of ALUResult for forwarding
//   stall_o          freeze upstream
//   data_*           bus request side (req, wr, size, addr, wdata, be)
//   data_addr_ok     request accepted
//   data_data_ok     response valid, data_rdata carries read data
//   valid_o ... PCout registered write-back bundle
//   exception_o      000 none, 100 AdEL, 101 AdES, 110 bus timeout
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  MemReadType,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        hiloWrite,
  input  logic [6:0]  WriteRegister,
  input  logic [63:0] hiloData,
  input  logic [31:0] PCin,
  output logic [31:0] ForwardMEM,
  output logic        stall_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_be,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        valid_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        hiloWrite_o,
  output logic [6:0]  WriteRegister_o,
  output logic [31:0] Result_o,
  output logic [63:0] hiloData_o,
  output logic [31:0] PCout,
  output logic [2:0]  exception_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          valid_q, valid_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic          hilo_write_q, hilo_write_d;
  logic [6:0]    write_register_q, write_register_d;
  logic [31:0]   result_q, result_d;
  logic [63:0]   hilo_data_q, hilo_data_d;
  logic [31:0]   pc_q, pc_d;
  logic [2:0]    exception_q, exception_d;

  logic          is_mem, is_half, is_byte, is_word, align_exc;
  logic [31:0]   eff_addr, load_lane, load_ext, wdata;
  logic [3:0]    be_base;
  logic [1:0]    size;
  logic          tmo_hit, stall_busy, commit;

  assign ForwardMEM = ALUResult;

  // Decode of the held input bundle: width, alignment, bus fields, load data.
  always_comb begin
    is_mem  = MemRead | MemWrite;
    is_half = (MemReadType == 3'b001) | (MemReadType == 3'b010);
    is_byte = (MemReadType == 3'b011) | (MemReadType == 3'b100);
    is_word = ~(is_half | is_byte);
`ifdef MEM_ALIGN_CHECK_EN
    align_exc = is_mem & ((is_half & ALUResult[0]) | (is_word & (ALUResult[1:0] != 2'b00)));
    eff_addr  = ALUResult;
`else
    align_exc = 1'b0;
    // Halves drop bit 0, words drop bits 1:0; bytes keep the full address.
    eff_addr  = {ALUResult[31:2], ALUResult[1] & ~is_word, ALUResult[0] & is_byte};
`endif
    be_base = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);
    size    = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
    wdata   = is_byte ? {4{MemData[7:0]}} : (is_half ? {2{MemData[15:0]}} : MemData);
    // Bring the addressed lane down to bit 0, then extend.
    load_lane = rdata_q >> {eff_addr[1:0], 3'b000};
    case (MemReadType)
      3'b001:  load_ext = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b010:  load_ext = {16'h0000, load_lane[15:0]};
      3'b011:  load_ext = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b100:  load_ext = {24'h000000, load_lane[7:0]};
      default: load_ext = load_lane;
    endcase
  end

  // cnt_q holds the number of REQ/WAIT cycles already spent, so the hit fires
  // in the TIMEOUT-th bus cycle.
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Reset pulls stall low at once, even while a memory op sits on the inputs.
  assign stall_o = stall_busy & rst;

  always_comb begin
    state_d          = state_q;
    cnt_d            = '0;
    tmo_d            = tmo_q;
    rdata_d          = rdata_q;
    stall_busy       = 1'b0;
    commit           = 1'b0;
    data_req         = 1'b0;
    data_wr          = 1'b0;
    data_size        = 2'd0;
    data_addr        = 32'h0;
    data_wdata       = 32'h0;
    data_be          = 4'h0;
    valid_d          = 1'b0;
    reg_write_d      = reg_write_q;
    mem_to_reg_d     = mem_to_reg_q;
    hilo_write_d     = hilo_write_q;
    write_register_d = write_register_q;
    result_d         = result_q;
    hilo_data_d      = hilo_data_q;
    pc_d             = pc_q;
    exception_d      = exception_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (is_mem && !align_exc) begin
            stall_busy = 1'b1;
            state_d    = ST_REQ;
          end else begin
            commit = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_busy = 1'b1;
        data_req   = 1'b1;
        data_wr    = MemWrite;
        data_size  = size;
        data_addr  = eff_addr;
        data_wdata = wdata;
        data_be    = be_base << eff_addr[1:0];
        if (data_addr_ok && data_data_ok) begin
          rdata_d = data_rdata;
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (data_addr_ok) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_busy = 1'b1;
        if (data_data_ok) begin
          rdata_d = data_rdata;
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin  // ST_DONE
        commit  = 1'b1;
        tmo_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // One write-back bundle for both paths: immediate (IDLE) and after the bus
    // (DONE). align_exc is only ever set on the IDLE path, tmo_q only on DONE.
    if (commit) begin
      valid_d          = 1'b1;
      reg_write_d      = RegWrite & ~align_exc & ~tmo_q;
      mem_to_reg_d     = MemtoReg;
      hilo_write_d     = hiloWrite & ~align_exc;
      write_register_d = WriteRegister;
      result_d         = (MemRead && !align_exc && !tmo_q) ? load_ext : ALUResult;
      hilo_data_d      = hiloData;
      pc_d             = PCin;
      if (tmo_q)          exception_d = 3'b110;
      else if (align_exc) exception_d = MemRead ? 3'b100 : 3'b101;
      else                exception_d = 3'b000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      tmo_q            <= 1'b0;
      rdata_q          <= 32'h0;
      valid_q          <= 1'b0;
      reg_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      hilo_write_q     <= 1'b0;
      write_register_q <= 7'h0;
      result_q         <= 32'h0;
      hilo_data_q      <= 64'h0;
      pc_q             <= 32'h0;
      exception_q      <= 3'b000;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      tmo_q            <= tmo_d;
      rdata_q          <= rdata_d;
      valid_q          <= valid_d;
      reg_write_q      <= reg_write_d;
      mem_to_reg_q     <= mem_to_reg_d;
      hilo_write_q     <= hilo_write_d;
      write_register_q <= write_register_d;
      result_q         <= result_d;
      hilo_data_q      <= hilo_data_d;
      pc_q             <= pc_d;
      exception_q      <= exception_d;
    end
  end

  assign valid_o         = valid_q;
  assign RegWrite_o      = reg_write_q;
  assign MemtoReg_o      = mem_to_reg_q;
  assign hiloWrite_o     = hilo_write_q;
  assign WriteRegister_o = write_register_q;
  assign Result_o        = result_q;
  assign hiloData_o      = hilo_data_q;
  assign PCout           = pc_q;
  assign exception_o     = exception_q;

endmodule
